// File: rtl/regfile_stream_reader_if.sv
// Beat stream carrying register contents out of the readback engine.
// The engine drives the master side; the sink drives m_ready.
interface regfile_stream_reader_if #(
    parameter int WIDTH = 1,
    parameter int AW    = 1
);
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic [AW-1:0]    m_addr;
    logic             m_last;

    modport master (output m_valid, m_data, m_addr, m_last, input m_ready);
    modport slave  (input m_valid, m_data, m_addr, m_last, output m_ready);
endinterface

// File: rtl/regfile_stream_reader.sv
// Drains a contiguous, wrapping address window from a combinational register-file
// read port into a valid/ready beat stream tagged with address and last flag.
module regfile_stream_reader #(
    parameter int WIDTH = 1,
    parameter int N_REG = 1,
    localparam int AW  = $clog2(N_REG),
    // N_REG==1 still needs a physical address bit; it simply stays 0.
    localparam int AWI = (AW == 0) ? 1 : AW
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [AWI-1:0]          base_addr,
    input  logic [AW:0]             count,
    output logic                    busy,
    output logic                    done,
    output logic [AWI-1:0]          rf_raddr,
    input  logic [WIDTH-1:0]        rf_rdata,
    regfile_stream_reader_if.master m
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    localparam logic [AW:0]    N_REG_C  = (AW+1)'(N_REG);
    localparam logic [AW:0]    REM_ONE  = (AW+1)'(1);
    localparam logic [AWI-1:0] ADDR_ONE = AWI'(1);
    localparam logic [AWI-1:0] ADDR_MAX = AWI'(N_REG - 1);

    state_t           state_reg, state_next;
    logic [AWI-1:0]   addr_reg, addr_next;
    logic [AW:0]      rem_reg, rem_next;
    logic             valid_reg, valid_next;
    logic [WIDTH-1:0] data_reg, data_next;
    logic [AWI-1:0]   beat_addr_reg, beat_addr_next;
    logic             last_reg, last_next;
    logic             done_reg, done_next;
    logic             load;
    logic [AW:0]      cnt_clamped;

    assign cnt_clamped = (count > N_REG_C) ? N_REG_C : count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        rem_next       = rem_reg;
        valid_next     = valid_reg;
        data_next      = data_reg;
        beat_addr_next = beat_addr_reg;
        last_next      = last_reg;
        done_next      = 1'b0;
        load           = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (cnt_clamped == '0) begin
                        done_next = 1'b1;
                    end else begin
                        addr_next  = base_addr;
                        rem_next   = cnt_clamped;
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                // Output register refills whenever it is empty or being drained.
                load = (!valid_reg || m.m_ready) && (rem_reg != '0);
                if (load) begin
                    data_next      = rf_rdata;
                    beat_addr_next = addr_reg;
                    last_next      = (rem_reg == REM_ONE);
                    valid_next     = 1'b1;
                    addr_next      = (addr_reg == ADDR_MAX) ? '0 : addr_reg + ADDR_ONE;
                    rem_next       = rem_reg - REM_ONE;
                    if (rem_reg == REM_ONE) begin
                        state_next = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (valid_reg && m.m_ready) begin
                    valid_next = 1'b0;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_reg      <= '0;
            rem_reg       <= '0;
            valid_reg     <= 1'b0;
            data_reg      <= '0;
            beat_addr_reg <= '0;
            last_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            addr_reg      <= addr_next;
            rem_reg       <= rem_next;
            valid_reg     <= valid_next;
            data_reg      <= data_next;
            beat_addr_reg <= beat_addr_next;
            last_reg      <= last_next;
            done_reg      <= done_next;
        end
    end

    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;
    assign rf_raddr  = addr_reg;
    assign m.m_valid = valid_reg;
    assign m.m_data  = data_reg;
    assign m.m_addr  = beat_addr_reg;
    assign m.m_last  = last_reg;
endmodule

// File: doc/regfile_stream_reader.md
Name: regfile_stream_reader

Overview:
- Streaming readback engine that drains a contiguous address window from one read port of the team's register files (combinational read: rdata valid the same cycle as raddr).
- Converts a start/base/count command into a valid/ready beat stream of register contents, tagged with address and last flag.
- Used for debug dump, context save and checkpoint paths; the register file write side is untouched.

Parameters:
- WIDTH, 1, width of each register and of the stream data.
- N_REG, 1, number of registers in the target register file; address width AW = $clog2(N_REG).

Ports:
- clk  input  1  clock.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  command strobe, sampled only in IDLE.
- base_addr  input  AW  first register address of the window.
- count  input  AW+1  number of registers to read, 0..N_REG.
- busy  output  1  high while a command is in progress.
- done  output  1  one-cycle pulse at command completion.
- rf_raddr  output  AW  address to the register file read port.
- rf_rdata  input  WIDTH  data from the register file read port, same cycle.
- m_valid  output  1  stream beat valid.
- m_ready  input  1  stream beat accepted by the sink.
- m_data  output  WIDTH  register contents.
- m_addr  output  AW  address the beat was read from.
- m_last  output  1  final beat of the command.

Behaviour:
- Reset: asynchronous, active-low; clk and rstn as stated above, fixed.
  - All outputs are 0 in reset: busy, done, m_valid, m_data, m_addr, m_last, rf_raddr.
  - FSM is in IDLE and all counters are 0.
- FSM states: IDLE, RUN, FLUSH.
  - IDLE: start=1 with count>0 captures base_addr into the addr counter and count into the remaining counter, then goes to RUN.
  - IDLE: start=1 with count==0 pulses done on the next cycle and stays in IDLE; no beats, busy stays 0.
  - IDLE: count>N_REG is clamped to N_REG.
  - RUN: rf_raddr = addr counter (registered); in IDLE it holds its last value.
  - RUN: the output register loads when (!m_valid || m_ready) and remaining>0.
    - Load: m_data=rf_rdata, m_addr=rf_raddr, m_last=(remaining==1), m_valid=1.
    - On load, addr increments, wrapping from N_REG-1 to 0 (also for non-power-of-two N_REG), and remaining decrements.
    - When the loaded beat has m_last=1, go to FLUSH.
  - FLUSH: the last beat is held until m_valid&&m_ready, then done=1 for one cycle and the FSM returns to IDLE.
- busy = (state != IDLE). It asserts the cycle after start is accepted and deasserts in the same cycle done pulses.
- Latency: start sampled at edge 0; RUN during cycle 1; first m_valid from cycle 2.
- Throughput: 1 beat/cycle while m_ready=1.
- Backpressure:
  - While m_valid && !m_ready, m_data, m_addr and m_last are held stable.
  - No load occurs and addr does not advance.
- Stream protocol:
  - m_valid never drops without a handshake.
  - Exactly `count` beats are issued per command.
  - Beat k carries address (base_addr+k) mod N_REG.
- Simultaneous events: start while busy is ignored, with no effect on the current command or on captured state.
- Data coherence: rf_rdata is sampled at load time. Register writes made after a beat is loaded are not reflected in that beat.
- Reset mid-operation: rstn low aborts immediately.
  - All state and outputs return to reset values; no done pulse is issued.
  - A beat in flight is dropped.
- N_REG==1: AW is 0; hold the address as a 1-bit internal counter that is always 0.

Test Plan:
- Basic dump: N_REG=8, regfile preloaded with reg[i]=0x10+i; start with base=2, count=4, m_ready=1.
  - Beats (addr,data) = (2,0x12),(3,0x13),(4,0x14),(5,0x15); m_last only on the 4th beat.
  - First m_valid 2 cycles after start; done one cycle after the final handshake.
- Wrap-around: N_REG=6, base=4, count=5 -> addresses 4,5,0,1,2 in order; m_last on addr 2.
- Backpressure: as the basic dump, but m_ready low for 3 cycles on beat 2.
  - m_data=0x13 and m_addr=3 stay stable throughout; rf_raddr stays at 4; the total is still 4 beats.
- Edge counts:
  - count=0 -> done pulse in cycle 1, busy=0, no m_valid.
  - count=N_REG=8, base=0 -> 8 beats, addresses 0..7.
  - count=9 -> clamped to 8 beats.
- Ignored start: pulse start with base=0, count=2 during the RUN of a base=2, count=4 command -> only the original 4 beats, one done pulse.
- Reset mid-command: assert rstn=0 after beat 2 is accepted.
  - All outputs go to 0 asynchronously; no done pulse.
  - After release, a new start (base=0, count=1) yields beat (0,0x10).
